alu_issue_pipe: RTL and testbench
=================================

// Module: alu_issue_pipe
// PURPOSE
//  Upstream issue/capture stage for the 16-bit combinational ALU. Accepts ALU commands over a
//  valid/ready handshake, registers operands (stage S1), drives the ALU from S1, and captures
//  outW/zer/neg into a result register (stage S2) with its own valid/ready handshake.
//  Keeps a 16-bit accumulator with forwarding, so dependent chains issue back-to-back.
// PARAMETERS
//  W       16  datapath width; fixed at 16 to match the ALU.
//  CNT_W   8   width of the completed-result counter.
// PORTS
//  clk        in   1     single clock, rising edge.
//  rst_n      in   1     synchronous, active-low reset.
//  cmd_valid  in   1     command present.
//  cmd_ready  out  1     stage can accept a command this cycle.
//  cmd_opc    in   3     ALU opcode 0..7. 7 is illegal.
//  cmd_a      in   W     operand A. Ignored when cmd_acc=1.
//  cmd_b      in   W     operand B.
//  cmd_cin    in   1     carry-in. Used by opc 2 only; forced to 0 for all other opcodes.
//  cmd_acc    in   1     1: operand A = accumulator (with forwarding).
//  res_valid  out  1     result register holds an unconsumed result.
//  res_ready  in   1     downstream consumes the result.
//  res_w      out  W     captured ALU result.
//  res_zer    out  1     captured zero flag.
//  res_neg    out  1     captured negative flag.
//  res_ill    out  1     captured result came from illegal opc 7.
//  acc_q      out  W     accumulator value.
//  done_cnt   out  CNT_W count of results accepted downstream.
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): S1/S2 valid=0, acc_q=0, done_cnt=0.
//   res_w=0, res_zer=1, res_neg=0, res_ill=0; all operand registers cleared.
//   Reset has priority over every event and drops in-flight commands. Outputs are valid on the first edge after reset.
//  Flow control:
//   adv = !res_valid | res_ready.
//   cmd_ready = !s1_valid | adv (combinational, no dependence on cmd_valid).
//  Accept: on cmd_valid & cmd_ready, S1 captures opc, B, cin (masked), and A.
//   A = cmd_acc ? (s1_valid ? alu_outW : acc_q) : cmd_a.
//   Forwarding is safe because a full S1 only accepts when it is advancing the same edge.
//  S1 -> S2: on s1_valid & adv, S2 captures outW, zer, neg, and ill=(opc==7); res_valid<=1 and acc_q<=outW.
//   If no new command is accepted that edge, s1_valid<=0.
//  S2 drain: on res_valid & res_ready without a refill, res_valid<=0. res_* data hold their last value.
//   done_cnt increments on every res_valid & res_ready and wraps 2^CNT_W-1 -> 0.
//  Latency: command accepted at edge N -> res_valid high after edge N+1 (2 cycles).
//   Throughput is 1 command/cycle with res_ready held high.
//  Stall: res_valid & !res_ready. S2 and S1 hold, cmd_ready = !s1_valid. res_* stable while stalled.
//  Simultaneous: S2 drain, S1->S2 transfer and new accept may all occur on one edge.
//  Arithmetic: follows the ALU exactly (two's complement, mod 2^16).
//   opc 3 uses an arithmetic shift of B; opc 6 = {A[7:0],B[7:0]}.
//   opc 7 yields res_w=0, res_zer=1, res_ill=1; acc_q is still updated to 0.
//  No combinational path from res_ready to res_* data.
// STRUCTURE
//  Shared include alu_defs.vh: opcode localparams and W:
//   OPC_NEG=0, OPC_INC=1, OPC_ADD=2, OPC_ADDSH=3, OPC_AND=4, OPC_OR=5, OPC_PACK=6, OPC_ILL=7.
//  One sub-module: an instance of ALU_behavioral fed from the S1 registers. inC = s1_cin.
//  Two-stage valid/ready logic inline; no explicit FSM beyond the two valid bits (states EMPTY/S1/S2/BOTH).
// TESTING
//  1 Reset: hold rst_n=0 two edges mid-stream -> res_valid=0, acc_q=0, done_cnt=0, res_zer=1, cmd_ready=1.
//  2 Add with carry: opc2, A=16'h7FFF, B=16'h0000, cin=1 -> res_w=16'h8000, neg=1, zer=0, 2 cycles after accept.
//  3 Back-to-back forwarding, res_ready=1:
//    opc1 A=5; then opc1 acc=1; then opc0 acc=1 -> results 6, 7, 16'hFFF9 on consecutive cycles; acc_q=16'hFFF9.
//  4 Stall: res_ready=0 with two commands issued (opc4 F0F0&0FF0 -> 00F0; opc5 -> ...) ->
//    cmd_ready=0 after the 2nd accept; res_w holds 16'h00F0.
//    Release -> both delivered in order; done_cnt += 2.
//  5 Corner ops:
//    opc3 A=0, B=16'h8000 -> 16'hC000, neg=1.
//    opc6 A=16'h12AB, B=16'h34CD -> 16'hABCD.
//    opc2 A=1, B=16'hFFFF, cin=0 -> 0, zer=1.
//    opc7 -> res_ill=1, res_w=0.
//    opc1 with cin=1 -> cin masked, A+1 only.
//  6 Counter wrap: 256 results accepted from done_cnt=0 -> done_cnt wraps to 0.
//    Randomised valid/ready vs reference model: no loss, duplication or reordering.

Source files
------------

// File: rtl/alu_issue_pipe_pkg.sv
// alu_issue_pipe_pkg: shared opcodes, datapath width and the captured-result record
package alu_issue_pipe_pkg;
  localparam int W = 16;
  typedef enum logic [2:0] {
    OPC_NEG   = 3'd0,
    OPC_INC   = 3'd1,
    OPC_ADD   = 3'd2,
    OPC_ADDSH = 3'd3,
    OPC_AND   = 3'd4,
    OPC_OR    = 3'd5,
    OPC_PACK  = 3'd6,
    OPC_ILL   = 3'd7
  } opc_e;
  typedef struct packed {
    logic [W-1:0] w;
    logic         zer;
    logic         neg;
    logic         ill;
  } res_t;
endpackage

// File: rtl/alu_issue_pipe_alu.sv
// alu_issue_pipe_alu: 16-bit combinational ALU producing result, zero/negative and illegal-opcode flags
module alu_issue_pipe_alu
  import alu_issue_pipe_pkg::*;
(
  input  opc_e         opc_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output res_t         res_o
);
  logic [W-1:0] w;
  always_comb begin
    w = '0;
    case (opc_i)
      OPC_NEG:   w = -a_i;
      OPC_INC:   w = a_i + W'(1);
      OPC_ADD:   w = a_i + b_i + W'(cin_i);
      OPC_ADDSH: w = a_i + {b_i[W-1], b_i[W-1:1]};
      OPC_AND:   w = a_i & b_i;
      OPC_OR:    w = a_i | b_i;
      OPC_PACK:  w = {a_i[7:0], b_i[7:0]};
      default:   w = '0;
    endcase
  end
  assign res_o = '{w: w, zer: ~|w, neg: w[W-1], ill: opc_i == OPC_ILL};
endmodule

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: two-stage valid/ready issue/capture wrapper around the ALU with accumulator forwarding
module alu_issue_pipe
  import alu_issue_pipe_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opc,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_w,
  output logic             res_zer,
  output logic             res_neg,
  output logic             res_ill,
  output logic [W-1:0]     acc_q,
  output logic [CNT_W-1:0] done_cnt
);
  logic             s1_valid_q, res_valid_q, s1_cin_q;
  opc_e             s1_opc_q;
  logic [W-1:0]     s1_a_q, s1_b_q, a_d;
  logic [CNT_W-1:0] cnt_q;
  res_t             res_q, alu_res;
  logic             adv, accept;
  assign adv       = !res_valid_q || res_ready;
  assign cmd_ready = !s1_valid_q || adv;
  assign accept    = cmd_valid && cmd_ready;
  // a full S1 only accepts while advancing, so the live ALU output is the next accumulator
  assign a_d = cmd_acc ? (s1_valid_q ? alu_res.w : acc_q) : cmd_a;
  alu_issue_pipe_alu alu_behavioral (
    .opc_i(s1_opc_q),
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .cin_i(s1_cin_q),
    .res_o(alu_res)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_opc_q    <= OPC_NEG;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '{w: '0, zer: 1'b1, neg: 1'b0, ill: 1'b0};
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_opc_q   <= opc_e'(cmd_opc);
        s1_a_q     <= a_d;
        s1_b_q     <= cmd_b;
        s1_cin_q   <= cmd_cin && opc_e'(cmd_opc) == OPC_ADD;
      end else if (adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_valid_q && adv) begin
        res_q       <= alu_res;
        res_valid_q <= 1'b1;
        acc_q       <= alu_res.w;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (res_valid_q && res_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign res_valid = res_valid_q;
  assign res_w     = res_q.w;
  assign res_zer   = res_q.zer;
  assign res_neg   = res_q.neg;
  assign res_ill   = res_q.ill;
  assign done_cnt  = cnt_q;
endmodule

// File: tb/tb_alu_issue_pipe.sv
// tb_alu_issue_pipe: directed scenarios plus randomized traffic scored against an in-order result model
module tb_alu_issue_pipe;
  typedef struct packed {
    logic [15:0] w;
    logic        zer;
    logic        neg;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_cin = 1'b0, cmd_acc = 1'b0, res_ready = 1'b0;
  logic [2:0]  cmd_opc = 3'd0;
  logic [15:0] cmd_a = 16'd0, cmd_b = 16'd0;
  logic        cmd_ready, res_valid, res_zer, res_neg, res_ill;
  logic [15:0] res_w, acc_q;
  logic [7:0]  done_cnt;
  int          total = 0, bad = 0;
  exp_t        q[$];
  exp_t        m_e;
  logic [15:0] m_acc = 16'd0;
  logic [7:0]  m_done = 8'd0;

  alu_issue_pipe dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opc(cmd_opc), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_acc(cmd_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_zer(res_zer),
    .res_neg(res_neg), .res_ill(res_ill), .acc_q(acc_q), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_alu(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin);
    logic [15:0] w;
    case (opc)
      3'd0:    w = ~a + 16'd1;
      3'd1:    w = a + 16'd1;
      3'd2:    w = a + b + {15'd0, cin};
      3'd3:    w = a + ((b >> 1) | (b & 16'h8000));
      3'd4:    w = a & b;
      3'd5:    w = a | b;
      3'd6:    w = {a[7:0], b[7:0]};
      default: w = 16'd0;
    endcase
    return '{w: w, zer: w == 16'd0, neg: w[15], ill: opc == 3'd7};
  endfunction

  // scoreboard: sees exactly what the next rising edge will sample
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_acc  = 16'd0;
      m_done = 8'd0;
    end else begin
      total++;
      if (done_cnt !== m_done) begin
        bad++;
        $display("FAIL sb_cnt done_cnt=%0d expected=%0d", done_cnt, m_done);
      end
      if (res_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_dup res_w=%h with no outstanding result", res_w);
        end else if ({res_w, res_zer, res_neg, res_ill} !== q[0]) begin
          bad++;
          $display("FAIL sb_data got w=%h z=%b n=%b i=%b expected w=%h z=%b n=%b i=%b",
                   res_w, res_zer, res_neg, res_ill, q[0].w, q[0].zer, q[0].neg, q[0].ill);
        end
        if (res_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          m_done++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_e = ref_alu(cmd_opc, cmd_acc ? m_acc : cmd_a, cmd_b, cmd_cin);
        q.push_back(m_e);
        m_acc = m_e.w;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic ac);
    logic ok;
    ok = 1'b0;
    cmd_opc = o; cmd_a = a; cmd_b = b; cmd_cin = c; cmd_acc = ac; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_timeout cmd_ready=%b required=1 within 50 cycles", cmd_ready);
    end
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    res_ready = 1'b1;
    issue(3'd1, 16'h0005, 16'h0, 1'b0, 1'b0);
    issue(3'd1, 16'h0009, 16'h0, 1'b0, 1'b0);
    repeat (2) tick();
    res_ready = 1'b0;
    issue(3'd5, 16'h1111, 16'h2222, 1'b0, 1'b0);
    issue(3'd4, 16'hFFFF, 16'h00FF, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    total += 7;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b required=0", res_valid); end
    if (acc_q !== 16'h0) begin bad++; $display("FAIL rst_acc got=%h required=0000", acc_q); end
    if (done_cnt !== 8'h0) begin bad++; $display("FAIL rst_done got=%0d required=0", done_cnt); end
    if (res_zer !== 1'b1) begin bad++; $display("FAIL rst_zer got=%b required=1", res_zer); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b required=1", cmd_ready); end
    if (res_w !== 16'h0) begin bad++; $display("FAIL rst_res_w got=%h required=0000", res_w); end
    if ({res_neg, res_ill} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b required=00", {res_neg, res_ill}); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    drain();
    issue(3'd2, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early res_valid=%b required=0", res_valid); end
    tick();
    total += 2;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL add_latency res_valid=%b required=1", res_valid); end
    if ({res_w, res_zer, res_neg} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_carry got w=%h z=%b n=%b required w=8000 z=0 n=1", res_w, res_zer, res_neg);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    cmd_valid = 1'b1; cmd_opc = 3'd1; cmd_a = 16'd5; cmd_b = 16'd0; cmd_cin = 1'b0; cmd_acc = 1'b0;
    tick();
    cmd_acc = 1'b1; cmd_a = 16'hDEAD;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b required=1", cmd_ready); end
    tick();
    total++;
    if (res_w !== 16'd6) begin bad++; $display("FAIL b2b_first got=%h required=0006", res_w); end
    cmd_opc = 3'd0;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (res_w !== 16'd7) begin bad++; $display("FAIL b2b_second got=%h required=0007", res_w); end
    tick();
    total += 2;
    if (res_w !== 16'hFFF9) begin bad++; $display("FAIL b2b_third got=%h required=FFF9", res_w); end
    if (acc_q !== 16'hFFF9) begin bad++; $display("FAIL b2b_acc got=%h required=FFF9", acc_q); end
  endtask

  task automatic test_stall();
    logic [7:0] d0;
    drain();
    res_ready = 1'b0;
    issue(3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    issue(3'd5, 16'h1234, 16'h0001, 1'b0, 1'b0);
    total += 2;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b required=0", cmd_ready); end
    if (res_w !== 16'h00F0) begin bad++; $display("FAIL stall_hold got=%h required=00F0", res_w); end
    repeat (3) tick();
    total += 2;
    if (res_w !== 16'h00F0) begin bad++; $display("FAIL stall_hold_late got=%h required=00F0", res_w); end
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_late got=%b required=0", cmd_ready); end
    d0 = m_done;
    res_ready = 1'b1;
    tick();
    total++;
    if (res_w !== 16'h1235) begin bad++; $display("FAIL stall_second got=%h required=1235", res_w); end
    tick();
    total += 2;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL stall_empty res_valid=%b required=0", res_valid); end
    if (done_cnt !== d0 + 8'd2) begin bad++; $display("FAIL stall_cnt got=%0d required=%0d", done_cnt, d0 + 8'd2); end
  endtask

  task automatic test_corner();
    logic [2:0]  t_opc[5] = '{3'd3, 3'd6, 3'd2, 3'd7, 3'd1};
    logic [15:0] t_a[5]   = '{16'h0000, 16'h12AB, 16'h0001, 16'h1234, 16'h000A};
    logic [15:0] t_b[5]   = '{16'h8000, 16'h34CD, 16'hFFFF, 16'h5678, 16'h0000};
    logic        t_c[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [18:0] t_e[5]   = '{{16'hC000, 3'b010}, {16'hABCD, 3'b010}, {16'h0000, 3'b100},
                              {16'h0000, 3'b101}, {16'h000B, 3'b000}};
    drain();
    for (int i = 0; i < 5; i++) begin
      issue(t_opc[i], t_a[i], t_b[i], t_c[i], 1'b0);
      tick();
      total += 2;
      if ({res_w, res_zer, res_neg, res_ill} !== t_e[i]) begin
        bad++;
        $display("FAIL corner_%0d got w=%h zni=%b%b%b required w=%h zni=%b", i, res_w, res_zer, res_neg,
                 res_ill, t_e[i][18:3], t_e[i][2:0]);
      end
      if (acc_q !== t_e[i][18:3]) begin
        bad++;
        $display("FAIL corner_acc_%0d got=%h required=%h", i, acc_q, t_e[i][18:3]);
      end
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      cmd_valid = 1'b1; cmd_opc = 3'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      cmd_cin = 1'($urandom); cmd_acc = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (done_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d required=255", done_cnt); end
    issue(3'd1, 16'h0001, 16'h0, 1'b0, 1'b0);
    repeat (3) tick();
    total++;
    if (done_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d required=0", done_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 2) != 0); cmd_opc = 3'($urandom);
      cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_cin = 1'($urandom); cmd_acc = 1'($urandom);
      res_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    total += 2;
    if (q.size() != 0) begin bad++; $display("FAIL rand_lost outstanding=%0d required=0", q.size()); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL rand_idle res_valid=%b required=0", res_valid); end
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    test_reset();
    test_add_carry();
    test_back_to_back();
    test_stall();
    test_corner();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
